// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller: one block per NR+1 cycles, result pushed NR edges after accept.
// Input accepted only when a FIFO slot is free (no overflow); output drains by valid/ready.
module aes_round_sequencer #(
   parameter int DATA_W    = 128,
   parameter int NR        = 10,
   parameter int ADDR_W    = 4,
   parameter int OUT_DEPTH = 2,
   localparam int CNT_W    = $clog2(OUT_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_mode,
   output logic [ADDR_W-1:0] round_key_addr,
   input  logic [DATA_W-1:0] round_key_input,
   output logic [DATA_W-1:0] rf_state,
   output logic [DATA_W-1:0] rf_key,
   output logic              rf_mode,
   output logic              rf_last,
   input  logic [DATA_W-1:0] rf_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_count,
   output logic              data_done,
   output logic              busy
);

   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam logic [ADDR_W-1:0] NR_A = ADDR_W'(NR);

   typedef enum logic {IDLE, ROUND} fsm_t;

   fsm_t              fsm_q, fsm_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] blk_q, blk_d;
   logic              mode_q, mode_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] mem_q [OUT_DEPTH];
   logic [DATA_W-1:0] mem_d [OUT_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      fsm_d          = fsm_q;
      cnt_d          = cnt_q;
      blk_d          = blk_q;
      mode_d         = mode_q;
      done_d         = 1'b0;
      push           = 1'b0;
      in_ready       = 1'b0;
      round_key_addr = '0;
      rf_last        = 1'b0;
      busy           = 1'b0;
      case (fsm_q)
         IDLE: begin
            in_ready       = !clear && (count_q < CNT_W'(OUT_DEPTH));
            round_key_addr = in_mode ? NR_A : '0;
            if (in_valid && in_ready) begin
               blk_d  = in_data ^ round_key_input;
               mode_d = in_mode;
               cnt_d  = ADDR_W'(1);
               fsm_d  = ROUND;
            end
         end
         ROUND: begin
            busy           = 1'b1;
            round_key_addr = mode_q ? (NR_A - cnt_q) : cnt_q;
            rf_last        = (cnt_q == NR_A);
            if (cnt_q < NR_A) begin
               blk_d = rf_result;
               cnt_d = cnt_q + 1'b1;
            end else begin
               push   = 1'b1;
               done_d = 1'b1;
               cnt_d  = '0;
               fsm_d  = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
      // Flush wins over everything except reset, including a push on the same edge.
      if (clear) begin
         fsm_d  = IDLE;
         cnt_d  = '0;
         done_d = 1'b0;
         push   = 1'b0;
      end
   end

   assign pop = (count_q != '0) && out_ready;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = rf_result;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         fsm_q    <= IDLE;
         cnt_q    <= '0;
         blk_q    <= '0;
         mode_q   <= 1'b0;
         done_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         fsm_q    <= fsm_d;
         cnt_q    <= cnt_d;
         blk_q    <= blk_d;
         mode_q   <= mode_d;
         done_q   <= done_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

   assign rf_state  = blk_q;
   assign rf_key    = round_key_input;
   assign rf_mode   = mode_q;
   assign out_valid = (count_q != '0);
   assign out_data  = mem_q[rd_ptr_q];
   assign out_count = count_q;
   assign data_done = done_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench: real AES-128 round unit and key store around the NR=10 build, XOR stub around an NR=14 build.
module tb_aes_round_sequencer;

   localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         n_rst, clear, in_valid, in_mode, out_ready;
   logic         in_ready, rf_mode, rf_last, out_valid, data_done, busy;
   logic [127:0] in_data, round_key_input, rf_state, rf_key, rf_result, out_data;
   logic [3:0]   round_key_addr;
   logic [1:0]   out_count;
   logic [127:0] rk [0:15];

   logic         b_clear, b_in_valid, b_in_mode, b_out_ready;
   logic         b_in_ready, b_rf_mode, b_rf_last, b_out_valid, b_data_done, b_busy;
   logic [15:0]  b_in_data, b_key, b_rf_state, b_rf_key, b_rf_result, b_out_data;
   logic [3:0]   b_addr;
   logic [1:0]   b_out_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   aes_round_sequencer #(.DATA_W(128), .NR(10), .ADDR_W(4), .OUT_DEPTH(2)) u_dut (
      .clk(clk), .n_rst(n_rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode), .round_key_addr(round_key_addr),
      .round_key_input(round_key_input), .rf_state(rf_state), .rf_key(rf_key),
      .rf_mode(rf_mode), .rf_last(rf_last), .rf_result(rf_result), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
      .data_done(data_done), .busy(busy));

   aes_round_sequencer #(.DATA_W(16), .NR(14), .ADDR_W(4), .OUT_DEPTH(2)) u_dut14 (
      .clk(clk), .n_rst(n_rst), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_mode(b_in_mode), .round_key_addr(b_addr),
      .round_key_input(b_key), .rf_state(b_rf_state), .rf_key(b_rf_key),
      .rf_mode(b_rf_mode), .rf_last(b_rf_last), .rf_result(b_rf_result), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_data(b_out_data), .out_count(b_out_count),
      .data_done(b_data_done), .busy(b_busy));

   // ---------------- AES reference round unit ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = xt(a);
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r = 8'h01;
      logic [7:0] e = 8'd254;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gmul(r, a);
         a = gmul(a, a);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] x = ginv(b);
      return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] isbox(input logic [7:0] s);
      return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] key,
                                              input logic dec, input logic last);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   m [4];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) b[i] = st[127-8*i -: 8];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            t[r+4*c] = dec ? isbox(b[r+4*((c-r+4)%4)]) : sbox(b[r+4*((c+r)%4)]);
      if (dec) begin
         for (int i = 0; i < 16; i++) t[i] = t[i] ^ key[127-8*i -: 8];
         m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      end else begin
         m = '{8'h02, 8'h03, 8'h01, 8'h01};
      end
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
               b[r] = 8'h00;
               for (int j = 0; j < 4; j++) b[r] = b[r] ^ gmul(t[j+4*c], m[(j-r+4)%4]);
            end
            for (int r = 0; r < 4; r++) t[r+4*c] = b[r];
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
      return dec ? o : (o ^ key);
   endfunction

   always_comb rf_result = aes_round(rf_state, rf_key, rf_mode, rf_last);
   assign round_key_input = rk[round_key_addr];

   // NR=14 stub: key k has every nibble equal to k, round = state ^ key.
   assign b_key       = {4{b_addr}};
   assign b_rf_result = b_rf_state ^ b_rf_key;

   task automatic key_expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox(tmp[31:24]) ^ rc, sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
            rc  = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 16; r++) rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
   endtask

   // ---------------- checking and stimulus helpers ----------------
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic send(input logic [127:0] d, input logic m);
      logic ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      for (int t = 0; t < 60 && !ok; t++) begin
         @(negedge clk);
         ok = in_ready;
         if (!ok) begin
            @(posedge clk);
            #1;
         end
      end
      if (!ok) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      logic seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(negedge clk);
         seen = data_done;
         @(posedge clk);
         #1;
      end
      check(tag, seen, 1);
   endtask

   task automatic pop_expect(input string tag, input logic [127:0] exp);
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_vld"}, out_valid, 1);
      check(tag, out_data, exp);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic watch_no_done(input string tag, input int cycles);
      logic seen = 1'b0;
      for (int t = 0; t < cycles; t++) begin
         @(negedge clk);
         seen = seen | data_done;
         @(posedge clk);
         #1;
      end
      check(tag, seen, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [127:0] prev, exp_o;
      logic         md;
      n_rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
      b_clear = 1'b0; b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
      key_expand(128'h000102030405060708090a0b0c0d0e0f);
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", data_done, 0);
      check("rst_last", rf_last, 0);
      check("rst_count", out_count, 0);
      check("rst_out_data", out_data, 0);
      check("rst_addr", round_key_addr, 0);
      @(posedge clk);
      #1;

      // T1: FIPS-197 C.1 encrypt, key order 1..10, result NR edges after accept
      send(PT, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         check($sformatf("t1_addr%0d", i), round_key_addr, i);
         check($sformatf("t1_last%0d", i), rf_last, (i == 10));
         check($sformatf("t1_busy%0d", i), busy, 1);
         if (i == 10) check("t1_not_yet", out_valid, 0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("t1_done", data_done, 1);
      check("t1_busy_off", busy, 0);
      check("t1_count", out_count, 1);
      check("t1_result", out_data, CT);
      @(posedge clk);
      #1;
      pop_expect("t1_pop", CT);
      @(negedge clk);
      check("t1_empty", out_valid, 0);
      check("t1_done_pulse", data_done, 0);
      @(posedge clk);
      #1;

      // T2: decrypt, key order 10..0; mode changes mid-block are ignored
      in_mode = 1'b1;
      @(negedge clk);
      check("t2_idle_addr", round_key_addr, 10);
      @(posedge clk);
      #1;
      send(CT, 1'b1);
      in_mode = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         check($sformatf("t2_addr%0d", i), round_key_addr, 10 - i);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("t2_done", data_done, 1);
      check("t2_result", out_data, PT);
      @(posedge clk);
      #1;
      pop_expect("t2_pop", PT);

      // T3: output stalled, FIFO of 2 fills and blocks a third block until a pop
      send(PT, 1'b0);
      wait_done("t3_done1");
      send(CT, 1'b1);
      wait_done("t3_done2");
      in_valid = 1'b1; in_data = PT; in_mode = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("t3_blocked", in_ready, 0);
      check("t3_count2", out_count, 2);
      check("t3_idle", busy, 0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("t3_head", out_data, CT);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("t3_ready_after_pop", in_ready, 1);
      check("t3_head2", out_data, PT);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("t3_busy3", busy, 1);
      @(posedge clk);
      #1;
      wait_done("t3_done3");
      pop_expect("t3_pop2", PT);
      pop_expect("t3_pop3", CT);

      // T4: pop and push on the same edge across pointer wrap
      send(PT, 1'b0);
      wait_done("t4_done0");
      prev = CT;
      for (int k = 1; k <= 4; k++) begin
         md    = k[0];
         exp_o = md ? PT : CT;
         send(md ? CT : PT, md);
         repeat (9) begin
            @(posedge clk);
            #1;
         end
         out_ready = 1'b1;
         @(negedge clk);
         check($sformatf("t4_head_before%0d", k), out_data, prev);
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         @(negedge clk);
         check($sformatf("t4_count%0d", k), out_count, 1);
         check($sformatf("t4_head_after%0d", k), out_data, exp_o);
         check($sformatf("t4_done%0d", k), data_done, 1);
         prev = exp_o;
         @(posedge clk);
         #1;
      end
      pop_expect("t4_pop_last", prev);

      // T5: clear at round 5 with one entry queued
      send(PT, 1'b0);
      wait_done("t5_done0");
      send(CT, 1'b1);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      @(negedge clk);
      check("t5_out_valid", out_valid, 0);
      check("t5_count", out_count, 0);
      check("t5_busy", busy, 0);
      @(posedge clk);
      #1;
      watch_no_done("t5_no_done", 12);
      clear = 1'b1;
      @(negedge clk);
      check("t5_ready_in_clear", in_ready, 0);
      @(posedge clk);
      #1;
      clear = 1'b0;
      send(CT, 1'b1);
      wait_done("t5_done_next");
      pop_expect("t5_next", PT);

      // T6a: reset pulse at round 3 discards the block
      send(PT, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("t6_addr3", round_key_addr, 3);
      n_rst = 1'b0;
      #1;
      check("t6_rst_busy", busy, 0);
      check("t6_rst_addr", round_key_addr, 0);
      check("t6_rst_valid", out_valid, 0);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      watch_no_done("t6_no_done", 14);
      check("t6_still_empty", out_valid, 0);
      send(PT, 1'b0);
      wait_done("t6_done_after");
      pop_expect("t6_result", CT);

      // T6b: NR=14 build, xor stub: result = data ^ 16'hFFFF
      b_in_mode = 1'b1;
      @(negedge clk);
      check("b_idle_addr_dec", b_addr, 14);
      @(posedge clk);
      #1;
      b_in_mode = 1'b0; b_in_data = 16'h1234; b_in_valid = 1'b1;
      @(negedge clk);
      check("b_ready", b_in_ready, 1);
      check("b_idle_addr", b_addr, 0);
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         check($sformatf("b_addr%0d", i), b_addr, i);
         check($sformatf("b_last%0d", i), b_rf_last, (i == 14));
         check($sformatf("b_nodone%0d", i), b_data_done, 0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("b_done", b_data_done, 1);
      check("b_result", b_out_data, 16'hEDCB);
      check("b_count", b_out_count, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
